// File: rtl/endmember_store_pkg.sv
// Shared constants, load FSM encoding and read-pipeline payload for the endmember store.
package endmember_store_pkg;

    localparam int unsigned I_WIDTH          = 16;
    localparam int unsigned SPECTRAL_BANDS   = 103;
    localparam int unsigned TOTAL_ENDMEMBERS = 20;
    localparam int unsigned ROW_W            = $clog2(SPECTRAL_BANDS);
    localparam int unsigned COL_W            = $clog2(TOTAL_ENDMEMBERS);
    localparam int unsigned DEPTH            = SPECTRAL_BANDS * TOTAL_ENDMEMBERS;
    localparam int unsigned ADDR_W           = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // One read request travelling down the latency delay line.
    typedef struct packed {
        logic              valid;
        logic              u_zero;
        logic              vt_zero;
        logic [ADDR_W-1:0] u_addr;
        logic [ADDR_W-1:0] vt_addr;
    } rd_stage_t;

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(ADDR_W'(row) * ADDR_W'(TOTAL_ENDMEMBERS) + ADDR_W'(col));
    endfunction

endpackage

// File: rtl/endmember_store_if.sv
// Load stream and dual read-port bus between the endmember selector/inversion engine and the store.
interface endmember_store_if;
    import endmember_store_pkg::*;

    logic                        load_start;
    logic [COL_W-1:0]            load_col;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [I_WIDTH-1:0]          wr_data;
    logic                        load_done;
    logic                        rd_valid;
    logic [ROW_W-1:0]            U_row;
    logic [COL_W-1:0]            U_col;
    logic [COL_W-1:0]            vT_row;
    logic [ROW_W-1:0]            vT_col;
    logic [I_WIDTH-1:0]          U_out;
    logic [I_WIDTH-1:0]          vT_out;
    logic                        rd_valid_out;
    logic [TOTAL_ENDMEMBERS-1:0] loaded;
    logic                        err;

    modport master (
        output load_start, load_col, wr_valid, wr_data,
        output rd_valid, U_row, U_col, vT_row, vT_col,
        input  wr_ready, load_done, U_out, vT_out, rd_valid_out, loaded, err
    );

    modport slave (
        input  load_start, load_col, wr_valid, wr_data,
        input  rd_valid, U_row, U_col, vT_row, vT_col,
        output wr_ready, load_done, U_out, vT_out, rd_valid_out, loaded, err
    );

endinterface

// File: rtl/endmember_ram.sv
// U matrix storage: one write port, two registered read ports with read-before-write behaviour.
module endmember_ram
    import endmember_store_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [I_WIDTH-1:0] wdata,
    input  logic               a_en,
    input  logic               a_zero,
    input  logic [ADDR_W-1:0]  a_addr,
    output logic [I_WIDTH-1:0] a_q,
    input  logic               b_en,
    input  logic               b_zero,
    input  logic [ADDR_W-1:0]  b_addr,
    output logic [I_WIDTH-1:0] b_q
);

    logic [I_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Outputs hold their last value between requests; masked requests return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_en) begin
                a_q <= a_zero ? '0 : mem[a_addr];
            end
            if (b_en) begin
                b_q <= b_zero ? '0 : mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/endmember_store.sv
// Endmember matrix store: column load FSM, loaded mask, range checks and fixed-latency read pipeline.
module endmember_store
    import endmember_store_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
)
(
    input  logic             clk,
    input  logic             rst,
    endmember_store_if.slave bus
);

    load_state_e       state;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  band_q;
    logic              wr_fire_c;
    logic              u_ok_c;
    logic              vt_ok_c;
    logic              rd_bad_c;
    rd_stage_t         req_c;
    rd_stage_t         ram_req;

    assign wr_fire_c = (state == ST_LOAD) && bus.wr_valid && bus.wr_ready;

    // Range check and loaded-mask gating happen at request time.
    always_comb begin
        u_ok_c  = (bus.U_row < ROW_W'(SPECTRAL_BANDS)) && (bus.U_col < COL_W'(TOTAL_ENDMEMBERS));
        vt_ok_c = (bus.vT_col < ROW_W'(SPECTRAL_BANDS)) && (bus.vT_row < COL_W'(TOTAL_ENDMEMBERS));
        rd_bad_c = bus.rd_valid && !(u_ok_c && vt_ok_c);
        req_c         = '0;
        req_c.valid   = bus.rd_valid;
        req_c.u_zero  = !(u_ok_c && bus.loaded[bus.U_col]);
        req_c.vt_zero = !(vt_ok_c && bus.loaded[bus.vT_row]);
        req_c.u_addr  = u_ok_c ? lin_addr(bus.U_row, bus.U_col) : '0;
        req_c.vt_addr = vt_ok_c ? lin_addr(bus.vT_col, bus.vT_row) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            col_q         <= '0;
            band_q        <= '0;
            bus.wr_ready  <= 1'b0;
            bus.load_done <= 1'b0;
            bus.loaded    <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            if (rd_bad_c) begin
                bus.err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    bus.wr_ready <= 1'b0;
                    if (bus.load_start) begin
                        if (bus.load_col < COL_W'(TOTAL_ENDMEMBERS)) begin
                            col_q                    <= bus.load_col;
                            band_q                   <= '0;
                            bus.loaded[bus.load_col] <= 1'b0;
                            bus.wr_ready             <= 1'b1;
                            state                    <= ST_LOAD;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_fire_c) begin
                        if (band_q == ROW_W'(SPECTRAL_BANDS - 1)) begin
                            band_q            <= '0;
                            bus.wr_ready      <= 1'b0;
                            bus.load_done     <= 1'b1;
                            bus.loaded[col_q] <= 1'b1;
                            state             <= ST_DONE;
                        end else begin
                            band_q <= band_q + ROW_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    bus.wr_ready <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    bus.wr_ready <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    // Requests are delayed READ_LATENCY-1 cycles; the RAM output register supplies the last one.
    generate
        if (READ_LATENCY <= 1) begin : g_no_dly
            assign ram_req = req_c;
        end else begin : g_dly
            rd_stage_t dly_q [READ_LATENCY-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= req_c;
                    for (int i = 1; i < int'(READ_LATENCY) - 1; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign ram_req = dly_q[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid_out <= 1'b0;
        end else begin
            bus.rd_valid_out <= ram_req.valid;
        end
    end

    endmember_ram u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_fire_c),
        .waddr  (lin_addr(band_q, col_q)),
        .wdata  (bus.wr_data),
        .a_en   (ram_req.valid),
        .a_zero (ram_req.u_zero),
        .a_addr (ram_req.u_addr),
        .a_q    (bus.U_out),
        .b_en   (ram_req.valid),
        .b_zero (ram_req.vt_zero),
        .b_addr (ram_req.vt_addr),
        .b_q    (bus.vT_out)
    );

endmodule

// File: doc/endmember_store.md
Name: endmember_store

Overview:
- Responder side of the inversion engine's U / new_vectorT fetch interface.
- Holds the endmember matrix U: SPECTRAL_BANDS rows x TOTAL_ENDMEMBERS columns, fixed-point samples of I_WIDTH bits.
- Accepts column loads from the upstream endmember selector over a valid/ready stream.
- Answers per-cycle address requests on two independent read ports (U element, new_vectorT element) with fixed pipelined latency. The reply strobe drives the inversion block's valid_in.

Parameters:
- I_WIDTH, 16, sample width in bits.
- SPECTRAL_BANDS, 103, rows of U (bands per endmember).
- TOTAL_ENDMEMBERS, 20, columns of U.
- READ_LATENCY, 2, cycles from request to reply; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_start  in  1  begin loading one column
- load_col  in  clog2(TOTAL_ENDMEMBERS)  column to load, sampled with load_start
- wr_valid  in  1  sample valid
- wr_ready  out  1  store accepts a sample
- wr_data  in  I_WIDTH  sample; band order 0..SPECTRAL_BANDS-1
- load_done  out  1  one-cycle pulse after the last sample of a column is written
- rd_valid  in  1  request valid (inversion addr_valid_out)
- U_row  in  clog2(SPECTRAL_BANDS)  U row (band)
- U_col  in  clog2(TOTAL_ENDMEMBERS)  U column
- vT_row  in  clog2(TOTAL_ENDMEMBERS)  new_vectorT row = endmember index (column of U)
- vT_col  in  clog2(SPECTRAL_BANDS)  new_vectorT column = band
- U_out  out  I_WIDTH  U[U_row][U_col]
- vT_out  out  I_WIDTH  U[vT_col][vT_row]
- rd_valid_out  out  1  reply valid (to inversion valid_in)
- loaded  out  TOTAL_ENDMEMBERS  bitmask of columns holding complete data
- err  out  1  sticky error flag

Behaviour:
Reset:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: wr_ready=0, load_done=0, rd_valid_out=0, U_out=0, vT_out=0, loaded=0, err=0, FSM=IDLE.
- All read-pipeline valid stages are cleared. Array contents are not reset.

Load FSM:
- States: IDLE, LOAD, DONE.
- IDLE:
  - wr_ready=0.
  - load_start with load_col < TOTAL_ENDMEMBERS: latch col, clear band counter, clear loaded[col], go to LOAD.
  - load_start with load_col >= TOTAL_ENDMEMBERS: set err, stay in IDLE.
- LOAD:
  - wr_ready=1.
  - Each cycle with wr_valid & wr_ready: write wr_data to U[band][col] and increment band.
  - Transfer at band == SPECTRAL_BANDS-1: go to DONE; band wraps to 0.
  - load_start is ignored in LOAD.
- DONE (one cycle): wr_ready=0, load_done=1, set loaded[col], go to IDLE.
- Minimum spacing between column loads is SPECTRAL_BANDS+2 cycles.
- Reset mid-load abandons the column. That column stays unloaded, so its reads return 0.

Read path:
- Fully pipelined, one request per cycle, no backpressure.
- A request at cycle t produces rd_valid_out and data at t+READ_LATENCY. Replies are in order, one per request. Idle cycles give rd_valid_out=0 and hold data at the previous value.
- U and vT ports are evaluated independently from the same array (two read ports).
- A port whose address is out of range returns 0 and sets err. Out of range means row >= SPECTRAL_BANDS or col >= TOTAL_ENDMEMBERS.
- A port reading a column with loaded[col]=0 returns 0. This does not set err.
- Same-cycle write and read of the same element: the read returns the pre-write value (read-before-write).
- Reading the column currently being loaded returns 0, because loaded is cleared at load_start.

Error handling:
- err is sticky until rst.

Decomposition:
- Shared package: I_WIDTH, SPECTRAL_BANDS and TOTAL_ENDMEMBERS defaults; derived address widths (clog2); the load FSM state encoding.
- One sub-module is natural: endmember_ram. It holds the SPECTRAL_BANDS*TOTAL_ENDMEMBERS x I_WIDTH array with one write port and two registered read ports; linear address is row*TOTAL_ENDMEMBERS+col.
- The top level keeps the load FSM, the loaded mask, the range checks and the latency delay line.

Test Plan:
1. Load col 3 with samples 0x0100+band, then request U_row=5, U_col=3 -> U_out=0x0105 with rd_valid_out exactly 2 cycles after rd_valid, and load_done pulses once, one cycle after the 103rd transfer.
2. Stream 103 back-to-back requests for U column 3 with the vT port at vT_row=3, vT_col=U_row -> 103 consecutive rd_valid_out, U_out==vT_out==0x0100+band, no gaps.
3. Request U_col=7 (never loaded) and U_row=110 (out of range) -> both return 0; err=1 only after the U_row=110 request.
4. Toggle wr_valid every other cycle during the load of col 0 -> load still completes after 103 accepted transfers and loaded[0]=1; load_start for col 1 during LOAD is ignored.
5. Assert rst after 50 samples of the col 2 load, then reload col 2 fully -> after reset loaded=0 and rd_valid_out=0; after the reload all 103 bands read back correctly.
6. load_col=25 with load_start -> stays IDLE, wr_ready=0, err=1.
